// File: rtl/wb_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_regfile_if : writeback/decode bus bundle for the Y86-64 SEQ regfile |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
interface wb_regfile_if #(
  parameter int WORD = 64
);
  logic [3:0]      icode;
  logic            cnd;
  logic [3:0]      dstE;
  logic [3:0]      dstM;
  logic [WORD-1:0] valE;
  logic [WORD-1:0] valM;
  logic            instr_valid;
  logic            imem_error;
  logic            dmem_error;
  logic [3:0]      srcA;
  logic [3:0]      srcB;
  logic [WORD-1:0] valA;
  logic [WORD-1:0] valB;
  logic [2:0]      stat;
  logic            halted;
  logic [WORD-1:0] retired;

  modport master (
    output icode, cnd, dstE, dstM, valE, valM,
    output instr_valid, imem_error, dmem_error, srcA, srcB,
    input  valA, valB, stat, halted, retired
  );

  modport slave (
    input  icode, cnd, dstE, dstM, valE, valM,
    input  instr_valid, imem_error, dmem_error, srcA, srcB,
    output valA, valB, stat, halted, retired
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_regfile : Y86-64 SEQ writeback, register file, status, retire count |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module wb_regfile #(
  parameter int         WORD  = 64,
  parameter int         NREG  = 15,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic        clk,
  input logic        rst,
  wb_regfile_if.slave bus
);

  typedef enum logic [2:0] {
    ST_AOK = 3'd1,
    ST_HLT = 3'd2,
    ST_ADR = 3'd3,
    ST_INS = 3'd4
  } stat_t;

  localparam logic [3:0] c_nreg       = 4'(NREG);
  localparam logic [3:0] c_icode_halt = 4'h0;
  localparam logic [3:0] c_icode_cmov = 4'h2;

  logic [WORD-1:0] r_regs [NREG];
  stat_t           r_stat;
  logic            r_halted;
  logic [WORD-1:0] r_retired;

  stat_t w_next_stat;
  logic  w_wr_en;
  logic  w_e_wr;
  logic  w_m_wr;

  always_comb begin
    w_next_stat = ST_AOK;
    if (bus.imem_error)             w_next_stat = ST_ADR;
    else if (!bus.instr_valid)      w_next_stat = ST_INS;
    else if (bus.dmem_error)        w_next_stat = ST_ADR;
    else if (bus.icode == c_icode_halt) w_next_stat = ST_HLT;
  end

  // Only an instruction that both starts and finishes in AOK may commit.
  assign w_wr_en = (r_stat == ST_AOK) && (w_next_stat == ST_AOK);

  assign w_e_wr = w_wr_en && (bus.dstE != RNONE) && (bus.dstE < c_nreg) &&
                  !((bus.icode == c_icode_cmov) && !bus.cnd);
  assign w_m_wr = w_wr_en && (bus.dstM != RNONE) && (bus.dstM < c_nreg);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_stat    <= ST_AOK;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_e_wr) begin
        r_regs[bus.dstE] <= bus.valE;
      end
      // M write follows E so it wins when both target the same register.
      if (w_m_wr) begin
        r_regs[bus.dstM] <= bus.valM;
      end
      if (r_stat == ST_AOK) begin
        r_stat   <= w_next_stat;
        r_halted <= (w_next_stat != ST_AOK);
      end
      if (w_wr_en) begin
        r_retired <= r_retired + WORD'(1);
      end
    end
  end

  assign bus.valA = ((bus.srcA != RNONE) && (bus.srcA < c_nreg)) ? r_regs[bus.srcA] : '0;
  assign bus.valB = ((bus.srcB != RNONE) && (bus.srcB < c_nreg)) ? r_regs[bus.srcB] : '0;

  assign bus.stat    = r_stat;
  assign bus.halted  = r_halted;
  assign bus.retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_regfile : directed self-checking bench for wb_regfile            |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_regfile_if #(.WORD(64)) bus ();

  wb_regfile #(.WORD(64), .NREG(15), .RNONE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural view of the writeback stage.
  logic [63:0] m_regs [15];
  int          m_stat;
  logic [63:0] m_ret;
  bit          m_valid = 1'b0;

  bit          pre_chk = 1'b0;
  logic [63:0] pre_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    int ns;
    if (rst) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_stat  = 1;
      m_ret   = 64'd0;
      m_valid = 1'b1;
    end else if (m_stat == 1) begin
      if (bus.imem_error)        ns = 3;
      else if (!bus.instr_valid) ns = 4;
      else if (bus.dmem_error)   ns = 3;
      else if (bus.icode == 0)   ns = 2;
      else                       ns = 1;
      if (ns == 1) begin
        if (bus.dstE != 4'hF && !(bus.icode == 4'd2 && !bus.cnd)) m_regs[bus.dstE] = bus.valE;
        if (bus.dstM != 4'hF) m_regs[bus.dstM] = bus.valM;
        m_ret = m_ret + 64'd1;
      end
      m_stat = ns;
    end
  endtask

  task automatic compare_all();
    logic [63:0] ea;
    logic [63:0] eb;
    if (!m_valid) return;
    ea = (bus.srcA < 4'd15) ? m_regs[bus.srcA] : 64'd0;
    eb = (bus.srcB < 4'd15) ? m_regs[bus.srcB] : 64'd0;
    check("valA", bus.valA, ea);
    check("valB", bus.valB, eb);
    check("stat", {61'd0, bus.stat}, 64'(m_stat));
    check("halted", {63'd0, bus.halted}, {63'd0, (m_stat != 1)});
    check("retired", bus.retired, m_ret);
  endtask

  // One clock: inputs already driven, compare mid-cycle, model on the edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    if (pre_chk) begin
      check("pre_edge_read", bus.valA, pre_val);
      pre_chk = 1'b0;
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic [3:0] ic, input logic c, input logic [3:0] de,
                      input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm,
                      input logic iv, input logic ie, input logic derr,
                      input logic [3:0] sa, input logic [3:0] sb);
    rst             = 1'b0;
    bus.icode       = ic;
    bus.cnd         = c;
    bus.dstE        = de;
    bus.valE        = ve;
    bus.dstM        = dm;
    bus.valM        = vm;
    bus.instr_valid = iv;
    bus.imem_error  = ie;
    bus.dmem_error  = derr;
    bus.srcA        = sa;
    bus.srcB        = sb;
    cycle();
  endtask

  // Reset while a write is pending, sweeping read IDs across all 16 values.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst             = 1'b1;
      bus.icode       = 4'd6;
      bus.cnd         = 1'b1;
      bus.dstE        = 4'd7;
      bus.valE        = 64'hDEAD;
      bus.dstM        = 4'd8;
      bus.valM        = 64'hBEEF;
      bus.instr_valid = 1'b1;
      bus.imem_error  = 1'b0;
      bus.dmem_error  = 1'b0;
      bus.srcA        = 4'(i);
      bus.srcB        = 4'(15 - i);
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);
    check("rst_stat", {61'd0, bus.stat}, 64'd1);
    check("rst_halted", {63'd0, bus.halted}, 64'd0);
    check("rst_retired", bus.retired, 64'd0);
    do_reset(16);
    bus.srcA = 4'd7;
    bus.srcB = 4'd8;
    #1;
    check("rst_discard_e", bus.valA, 64'd0);
    check("rst_discard_m", bus.valB, 64'd0);

    // Basic E write, with a same-cycle read returning the old value.
    pre_chk = 1'b1;
    pre_val = 64'd0;
    step(4'd6, 1'b0, 4'd3, 64'h2A, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd3, 4'hF);
    check("e_write", bus.valA, 64'h2A);
    check("e_retired", bus.retired, 64'd1);

    // cmov gating
    step(4'd2, 1'b0, 4'd5, 64'd99, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd3);
    check("cmov_nc", bus.valA, 64'd0);
    check("cmov_nc_ret", bus.retired, 64'd2);
    step(4'd2, 1'b1, 4'd5, 64'd99, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd3);
    check("cmov_c", bus.valA, 64'd99);

    // popq %rsp collision, then mrmovq
    step(4'd11, 1'b0, 4'd4, 64'h108, 4'd4, 64'h55, 1'b1, 1'b0, 1'b0, 4'd4, 4'd5);
    check("popq_rsp", bus.valA, 64'h55);
    step(4'd5, 1'b0, 4'hF, 64'd0, 4'd2, 64'd280, 1'b1, 1'b0, 1'b0, 4'd2, 4'd4);
    check("mrmovq", bus.valA, 64'd280);
    check("mrmovq_b", bus.valB, 64'h55);
    check("ret_5", bus.retired, 64'd5);

    // Data memory fault, then ignored clean write
    step(4'd5, 1'b0, 4'hF, 64'd0, 4'd1, 64'd7, 1'b1, 1'b0, 1'b1, 4'd1, 4'd2);
    check("dmem_nowrite", bus.valA, 64'd0);
    check("dmem_stat", {61'd0, bus.stat}, 64'd3);
    check("dmem_halted", {63'd0, bus.halted}, 64'd1);
    check("dmem_ret", bus.retired, 64'd5);
    step(4'd6, 1'b0, 4'd1, 64'd77, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd3);
    check("post_fault_write", bus.valA, 64'd0);
    check("post_fault_stat", {61'd0, bus.stat}, 64'd3);
    check("post_fault_ret", bus.retired, 64'd5);

    // imem_error outranks invalid instruction
    do_reset(2);
    step(4'd6, 1'b0, 4'd6, 64'd1, 4'hF, 64'd0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd3);
    check("imem_prio", {61'd0, bus.stat}, 64'd3);
    check("imem_nowrite", bus.valA, 64'd0);

    do_reset(2);
    step(4'd6, 1'b0, 4'd6, 64'd1, 4'hF, 64'd0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd3);
    check("ins_stat", {61'd0, bus.stat}, 64'd4);
    // Invalid instruction outranks a data memory error
    do_reset(2);
    step(4'd6, 1'b0, 4'd6, 64'd1, 4'hF, 64'd0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd3);
    check("ins_over_dmem", {61'd0, bus.stat}, 64'd4);

    // Halt, then recovery through reset
    do_reset(2);
    step(4'd1, 1'b0, 4'hF, 64'd0, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd6, 4'd3);
    step(4'd0, 1'b0, 4'd6, 64'd9, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd6, 4'd3);
    check("hlt_stat", {61'd0, bus.stat}, 64'd2);
    check("hlt_nowrite", bus.valA, 64'd0);
    check("hlt_ret", bus.retired, 64'd1);
    step(4'd6, 1'b0, 4'd6, 64'd9, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd6, 4'd3);
    check("hlt_sticky", {61'd0, bus.stat}, 64'd2);
    do_reset(1);
    check("recover_stat", {61'd0, bus.stat}, 64'd1);
    check("recover_ret", bus.retired, 64'd0);
    step(4'd6, 1'b0, 4'd3, 64'h1234, 4'hF, 64'd0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd14);
    check("recover_write", bus.valA, 64'h1234);
    check("recover_ret1", bus.retired, 64'd1);

    // RNONE destinations write nothing and reads of ID 15 give zero
    step(4'd6, 1'b0, 4'hF, 64'h77, 4'hF, 64'h88, 1'b1, 1'b0, 1'b0, 4'hF, 4'd3);
    check("rnone_read", bus.valA, 64'd0);
    check("rnone_keep", bus.valB, 64'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
